// File: rtl/gap_pool_unit_if.sv
// Stream interface for gap_pool_unit: 8-bit activation input with ready/valid,
// 8-bit average output stream with valid/last (no back-pressure on the output).
interface gap_pool_unit_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/gap_pool_unit.sv
// Global average pooling: accumulates CH interleaved channels over 2**PIX_LOG2 pixels,
// then streams the CH averages. Define GAP_ROUND_EN for round-half-up, else truncate.
module gap_pool_unit #(
  parameter int CH       = 32,
  parameter int PIX_LOG2 = 4
) (
  input logic         clk,
  input logic         rst_n,
  gap_pool_unit_if.slave bus
);

  localparam int AW = 8 + PIX_LOG2;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0]       CH_LAST  = CW'(CH - 1);
  localparam logic [PIX_LOG2-1:0] PIX_LAST = '1;

  typedef enum logic [1:0] {
    S_ACC = 2'b01,
    S_OUT = 2'b10
  } state_t;

  state_t              state;
  logic [CW-1:0]       ch_cnt;
  logic [CW-1:0]       out_cnt;
  logic [PIX_LOG2-1:0] pix_cnt;
  logic [AW-1:0]       acc [CH];
  logic [7:0]          out_data_q;
  logic                out_valid_q;
  logic                out_last_q;

`ifdef GAP_ROUND_EN
  localparam logic [AW:0] HALF = (AW + 1)'(1 << (PIX_LOG2 - 1));

  // One extra bit so the rounding add can reach 256 before saturation.
  function automatic logic [7:0] avg(input logic [AW-1:0] a);
    logic [AW:0] sum;
    logic [AW:0] sh;
    sum = {1'b0, a} + HALF;
    sh  = sum >> PIX_LOG2;
    return (|sh[AW:8]) ? 8'hFF : sh[7:0];
  endfunction
`else
  function automatic logic [7:0] avg(input logic [AW-1:0] a);
    logic [AW-1:0] sh;
    sh = a >> PIX_LOG2;
    return (|sh[AW-1:8]) ? 8'hFF : sh[7:0];
  endfunction
`endif

  // First pixel of a frame overwrites its accumulator, so frames need no clear cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ACC;
      ch_cnt      <= '0;
      pix_cnt     <= '0;
      out_cnt     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else begin
      case (state)
        S_ACC: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          if (bus.in_valid) begin
            if (pix_cnt == '0) acc[ch_cnt] <= AW'(bus.in_data);
            else               acc[ch_cnt] <= acc[ch_cnt] + AW'(bus.in_data);
            if (ch_cnt == CH_LAST) begin
              ch_cnt  <= '0;
              pix_cnt <= pix_cnt + 1'b1;
              if (pix_cnt == PIX_LAST) state <= S_OUT;
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
        end
        S_OUT: begin
          out_data_q  <= avg(acc[out_cnt]);
          out_valid_q <= 1'b1;
          out_last_q  <= (out_cnt == CH_LAST);
          if (out_cnt == CH_LAST) begin
            out_cnt <= '0;
            state   <= S_ACC;
          end else begin
            out_cnt <= out_cnt + 1'b1;
          end
        end
        default: begin
          state       <= S_ACC;
          ch_cnt      <= '0;
          pix_cnt     <= '0;
          out_cnt     <= '0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_ACC);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_gap_pool_unit.sv
// Directed, table-driven bench for gap_pool_unit: frame patterns with hand-computed averages,
// output timing, input stall during output, back-to-back frames and asynchronous reset.
module tb_gap_pool_unit;

  localparam int CH       = 32;
  localparam int PIX_LOG2 = 4;
  localparam int PIX      = 1 << PIX_LOG2;
  localparam int NVEC     = 8;
`ifdef GAP_ROUND_EN
  localparam logic [7:0] ALT0 = 8'd1;
`else
  localparam logic [7:0] ALT0 = 8'd0;
`endif

  // pattern: 0 = constant val, 1 = ch k carries k, 2 = ch0 alternates 0/1, others 255
  typedef struct {
    int         pattern;
    logic [7:0] val;
    bit         gaps;
    logic [7:0] exp_ch0;
    logic [7:0] exp_rest;
    bit         ramp;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;
  beat_t obs[$];
  vec_t  vecs[NVEC];
  int    hs_tab[NVEC];

  always #5 clk = ~clk;

  gap_pool_unit_if bus ();

  gap_pool_unit #(.CH(CH), .PIX_LOG2(PIX_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    if (bus.out_valid === 1'b1) begin
      b.data = bus.out_data;
      b.last = bus.out_last;
      b.cyc  = cyc;
      obs.push_back(b);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pixData(input vec_t v, input int p, input int c);
    case (v.pattern)
      0:       return v.val;
      1:       return 8'(c);
      default: return (c == 0) ? 8'(p % 2) : 8'd255;
    endcase
  endfunction

  function automatic logic [7:0] expData(input vec_t v, input int k);
    if (v.ramp) return 8'(k);
    return (k == 0) ? v.exp_ch0 : v.exp_rest;
  endfunction

  // Offers one beat, optionally after idle cycles; hs is the cycle the handshake completes in.
  task automatic applyStimulus(input logic [7:0] d, input bit gaps, output int hs);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      vec_cnt++;
      miss_cnt++;
      $display("[TB] FAIL in_ready timeout: got 0, expected 1");
    end
    hs = cyc;
    @(posedge clk);
  endtask

  task automatic sendFrame(input vec_t v, output int hs);
    for (int p = 0; p < PIX; p++)
      for (int c = 0; c < CH; c++)
        applyStimulus(pixData(v, p, c), v.gaps, hs);
  endtask

  task automatic waitBeats(input int n);
    int t;
    t = 0;
    while (obs.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (CH + 4) @(negedge clk);
    checkOutput("beat count", obs.size(), n);
  endtask

  task automatic checkFrame(input vec_t v, input int hs, input int base, input string tag);
    for (int k = 0; k < CH; k++) begin
      if (base + k >= obs.size()) begin
        vec_cnt++;
        miss_cnt++;
        $display("[TB] FAIL %s beat %0d missing: got none, expected data %0d", tag, k, expData(v, k));
      end else begin
        checkOutput($sformatf("%s data[%0d]", tag, k), obs[base+k].data, expData(v, k));
        checkOutput($sformatf("%s last[%0d]", tag, k), obs[base+k].last, (k == CH - 1));
        checkOutput($sformatf("%s cycle[%0d]", tag, k), obs[base+k].cyc, hs + 2 + k);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   hs;
    vec_t v;

    vecs[0] = '{1, 8'd0,   1'b0, 8'd0,   8'd0,   1'b1};
    vecs[1] = '{2, 8'd0,   1'b0, ALT0,   8'd255, 1'b0};
    vecs[2] = '{0, 8'd200, 1'b1, 8'd200, 8'd200, 1'b0};
    vecs[3] = '{0, 8'd10,  1'b0, 8'd10,  8'd10,  1'b0};
    vecs[4] = '{0, 8'd20,  1'b0, 8'd20,  8'd20,  1'b0};
    vecs[5] = '{1, 8'd0,   1'b1, 8'd0,   8'd0,   1'b1};
    vecs[6] = '{0, 8'd255, 1'b0, 8'd255, 8'd255, 1'b0};
    vecs[7] = '{0, 8'd0,   1'b1, 8'd0,   8'd0,   1'b0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset out_last", bus.out_last, 0);
    checkOutput("reset out_data", bus.out_data, 0);
    checkOutput("reset in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    // Single frame of 200s with in_ready window checked cycle by cycle.
    v = '{0, 8'd200, 1'b0, 8'd200, 8'd200, 1'b0};
    obs.delete();
    sendFrame(v, hs);
    for (int i = 1; i <= CH + 1; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput($sformatf("in_ready N+%0d", i), bus.in_ready, (i == CH + 1));
    end
    waitBeats(CH);
    checkFrame(v, hs, 0, "single200");

    // Table frames sent back to back; the next frame waits with in_valid high during output.
    obs.delete();
    for (int i = 0; i < NVEC; i++) begin
      sendFrame(vecs[i], hs);
      hs_tab[i] = hs;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    waitBeats(NVEC * CH);
    for (int i = 0; i < NVEC; i++)
      checkFrame(vecs[i], hs_tab[i], i * CH, $sformatf("vec%0d", i));

    // Reset in the middle of the output burst.
    v = '{0, 8'd50, 1'b0, 8'd50, 8'd50, 1'b0};
    sendFrame(v, hs);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midout rst out_valid", bus.out_valid, 0);
    checkOutput("midout rst out_data", bus.out_data, 0);
    checkOutput("midout rst in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset after 300 beats of a partial frame, then a clean frame of 7s.
    for (int i = 0; i < 300; i++) applyStimulus(8'd99, 1'b0, hs);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midframe rst out_valid", bus.out_valid, 0);
    checkOutput("midframe rst out_last", bus.out_last, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    obs.delete();
    v = '{0, 8'd7, 1'b0, 8'd7, 8'd7, 1'b0};
    sendFrame(v, hs);
    @(negedge clk);
    bus.in_valid = 1'b0;
    waitBeats(CH);
    checkFrame(v, hs, 0, "after_rst7");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
